gat_bram_loader: RTL and testbench
==================================

Name: gat_bram_loader

Overview:
- Upstream feeder for the GAT accelerator top level.
- Accepts a load command (target BRAM, word count) followed by a valid/ready stream of 32-bit words.
- Writes each word into the selected BRAM write port with byte addressing (word index << 2), one word per cycle.
- Raises the sticky per-BRAM load-done flags that gate the start of inference.

Parameters:
- TOP_WIDTH, 32, data/bus width of stream and BRAM din.
- H_DATA_DEPTH, 242101, h_data BRAM words.
- NODE_INFO_DEPTH, 13264, node_info BRAM words.
- WEIGHT_DEPTH, 22928, weight BRAM words.
- SUBGRAPH_IDX_DEPTH, 13264, subgraph index BRAM words.
- LEN_W, 18, width of cmd_len; must satisfy 2^LEN_W > max depth.
- Localparams: X_ADDR_W = $clog2(X_DEPTH) for each target; port address width = X_ADDR_W+2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  high only in IDLE
- cmd_sel  in  2  target: 0 h_data, 1 node_info, 2 wgt, 3 subgraph
- cmd_len  in  LEN_W  number of words to write (1..depth)
- s_valid  in  1  data word valid
- s_ready  out  1  data word ready
- s_data  in  TOP_WIDTH  data word
- load_clr  in  1  clear all done flags
- busy  out  1  high in LOAD
- cmd_err  out  1  one-cycle pulse on a rejected command
- {h_data,h_node_info,wgt,subgraph}_bram_din  out  TOP_WIDTH  write data
- {..}_bram_ena / {..}_bram_wea  out  1 each  write strobe pair (identical)
- h_data_bram_addra  out  H_DATA_ADDR_W+2  byte address; same pattern for the other three targets with their own widths
- h_data_bram_load_done, h_node_info_bram_load_done, wgt_bram_load_done, subgraph_bram_load_done  out  1 each  sticky done flags

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counters 0. Asserting rst mid-load aborts the load; no done flag is set.
- FSM IDLE:
  - cmd_ready=1.
  - On cmd_valid: if cmd_len==0 or cmd_len > depth(cmd_sel), pulse cmd_err for one cycle and stay in IDLE.
  - Otherwise latch sel and len, clear word counter, clear that target's done flag, go to LOAD.
- FSM LOAD:
  - busy=1, s_ready=1.
  - Each cycle with s_valid: register din=s_data, addra={cnt,2'b00}, ena=wea=1 on the selected port only, 1 cycle after acceptance; then cnt++.
  - Cycles without s_valid produce no write; ena=wea=0.
  - When the accepted beat has cnt==len-1, go to DONE.
- FSM DONE (1 cycle):
  - s_ready=0.
  - Set the target's done flag; it is visible the same cycle the last write strobe is on the BRAM port. Return to IDLE.
- Non-selected ports hold ena=wea=0. din and addra are don't-care when ena=0 but must not toggle (hold last value).
- Address wrap is impossible by the length check; the counter never exceeds len-1.
- Done flags:
  - Remain set until load_clr or a new accepted command to the same target.
  - load_clr in LOAD clears flags but does not abort the load; the flag is set again at DONE.
  - load_clr and a DONE set in the same cycle: set wins.
- s_data beats offered in IDLE/DONE are not accepted (s_ready=0).

Optional Feature:
- Macro GAT_LOADER_CHECKSUM_EN.
- When defined: extra output load_checksum [TOP_WIDTH-1:0], the modulo-2^32 sum of all words accepted in the most recent load.
  - Cleared at command accept.
  - Final value valid from the DONE cycle until the next accept.
- When undefined: the port is absent and no adder is synthesised.

Test Plan:
- Reset, then cmd_sel=2, cmd_len=4, words 0x11,0x22,0x33,0x44 back-to-back -> wgt_bram_addra 0,4,8,12 with ena=wea=1 on consecutive cycles; wgt_bram_load_done=1 on the last write cycle; other ports idle.
- cmd_sel=0, len=3, s_valid toggling 1,0,1,0,1 -> exactly 3 writes at byte addresses 0,4,8; no strobe on gap cycles; h_data done set after the third.
- cmd_sel=1, len=13265 -> cmd_err pulses once, no write occurs, state stays IDLE; len=0 -> same response.
- Load subgraph len=2, then pulse load_clr -> subgraph_bram_load_done returns to 0; reload len=2 -> flag returns to 1.
- Assert rst after 2 of 5 words -> all strobes and flags 0 immediately; next command accepted normally.
- With GAT_LOADER_CHECKSUM_EN defined, words 0xFFFFFFFF, 0x00000002 -> load_checksum=0x00000001 at DONE.

Source files
------------

// File: rtl/gat_bram_loader.sv
// Command + stream loader that fills the four GAT BRAMs and keeps sticky per-BRAM load-done flags.
// Optional GAT_LOADER_CHECKSUM_EN adds load_checksum, the mod-2^32 sum of the most recent load.
module gat_bram_loader #(
  parameter int TOP_WIDTH          = 32,
  parameter int H_DATA_DEPTH       = 242101,
  parameter int NODE_INFO_DEPTH    = 13264,
  parameter int WEIGHT_DEPTH       = 22928,
  parameter int SUBGRAPH_IDX_DEPTH = 13264,
  parameter int LEN_W              = 18,
  localparam int H_DATA_ADDR_W    = $clog2(H_DATA_DEPTH),
  localparam int NODE_INFO_ADDR_W = $clog2(NODE_INFO_DEPTH),
  localparam int WEIGHT_ADDR_W    = $clog2(WEIGHT_DEPTH),
  localparam int SUBGRAPH_ADDR_W  = $clog2(SUBGRAPH_IDX_DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [1:0]                  cmd_sel,
  input  logic [LEN_W-1:0]            cmd_len,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [TOP_WIDTH-1:0]        s_data,
  input  logic                        load_clr,
  output logic                        busy,
  output logic                        cmd_err,
  output logic [TOP_WIDTH-1:0]        h_data_bram_din,
  output logic                        h_data_bram_ena,
  output logic                        h_data_bram_wea,
  output logic [H_DATA_ADDR_W+1:0]    h_data_bram_addra,
  output logic [TOP_WIDTH-1:0]        h_node_info_bram_din,
  output logic                        h_node_info_bram_ena,
  output logic                        h_node_info_bram_wea,
  output logic [NODE_INFO_ADDR_W+1:0] h_node_info_bram_addra,
  output logic [TOP_WIDTH-1:0]        wgt_bram_din,
  output logic                        wgt_bram_ena,
  output logic                        wgt_bram_wea,
  output logic [WEIGHT_ADDR_W+1:0]    wgt_bram_addra,
  output logic [TOP_WIDTH-1:0]        subgraph_bram_din,
  output logic                        subgraph_bram_ena,
  output logic                        subgraph_bram_wea,
  output logic [SUBGRAPH_ADDR_W+1:0]  subgraph_bram_addra,
  output logic                        h_data_bram_load_done,
  output logic                        h_node_info_bram_load_done,
  output logic                        wgt_bram_load_done,
  output logic                        subgraph_bram_load_done
`ifdef GAT_LOADER_CHECKSUM_EN
  ,
  output logic [TOP_WIDTH-1:0]        load_checksum
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [LEN_W-1:0] H_DEPTH_L  = LEN_W'(H_DATA_DEPTH);
  localparam logic [LEN_W-1:0] N_DEPTH_L  = LEN_W'(NODE_INFO_DEPTH);
  localparam logic [LEN_W-1:0] W_DEPTH_L  = LEN_W'(WEIGHT_DEPTH);
  localparam logic [LEN_W-1:0] S_DEPTH_L  = LEN_W'(SUBGRAPH_IDX_DEPTH);

  state_t           state;
  logic [1:0]       sel;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] sel_depth;
  logic [3:0]       wr_en;
  logic [3:0]       done;

  always_comb begin
    sel_depth = H_DEPTH_L;
    case (cmd_sel)
      2'd0: sel_depth = H_DEPTH_L;
      2'd1: sel_depth = N_DEPTH_L;
      2'd2: sel_depth = W_DEPTH_L;
      2'd3: sel_depth = S_DEPTH_L;
      default: sel_depth = H_DEPTH_L;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                  <= IDLE;
      sel                    <= '0;
      len                    <= '0;
      cnt                    <= '0;
      wr_en                  <= '0;
      done                   <= '0;
      cmd_ready              <= 1'b0;
      s_ready                <= 1'b0;
      busy                   <= 1'b0;
      cmd_err                <= 1'b0;
      h_data_bram_din        <= '0;
      h_data_bram_addra      <= '0;
      h_node_info_bram_din   <= '0;
      h_node_info_bram_addra <= '0;
      wgt_bram_din           <= '0;
      wgt_bram_addra         <= '0;
      subgraph_bram_din      <= '0;
      subgraph_bram_addra    <= '0;
`ifdef GAT_LOADER_CHECKSUM_EN
      load_checksum          <= '0;
`endif
    end else begin
      cmd_err <= 1'b0;
      wr_en   <= '0;
      // Clear first so a same-cycle completion set below takes priority.
      if (load_clr) done <= '0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            if (cmd_len == '0 || cmd_len > sel_depth) begin
              cmd_err <= 1'b1;
            end else begin
              sel           <= cmd_sel;
              len           <= cmd_len;
              cnt           <= '0;
              done[cmd_sel] <= 1'b0;
              cmd_ready     <= 1'b0;
              s_ready       <= 1'b1;
              busy          <= 1'b1;
              state         <= LOAD;
`ifdef GAT_LOADER_CHECKSUM_EN
              load_checksum <= '0;
`endif
            end
          end
        end
        LOAD: begin
          if (s_valid) begin
            wr_en[sel] <= 1'b1;
            case (sel)
              2'd0: begin
                h_data_bram_din   <= s_data;
                h_data_bram_addra <= {cnt[H_DATA_ADDR_W-1:0], 2'b00};
              end
              2'd1: begin
                h_node_info_bram_din   <= s_data;
                h_node_info_bram_addra <= {cnt[NODE_INFO_ADDR_W-1:0], 2'b00};
              end
              2'd2: begin
                wgt_bram_din   <= s_data;
                wgt_bram_addra <= {cnt[WEIGHT_ADDR_W-1:0], 2'b00};
              end
              default: begin
                subgraph_bram_din   <= s_data;
                subgraph_bram_addra <= {cnt[SUBGRAPH_ADDR_W-1:0], 2'b00};
              end
            endcase
            cnt <= cnt + 1'b1;
`ifdef GAT_LOADER_CHECKSUM_EN
            load_checksum <= load_checksum + s_data;
`endif
            // Flag rises with the last write strobe so both are seen together.
            if (cnt == len - 1'b1) begin
              done[sel] <= 1'b1;
              s_ready   <= 1'b0;
              busy      <= 1'b0;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          done[sel] <= 1'b1;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign h_data_bram_ena      = wr_en[0];
  assign h_data_bram_wea      = wr_en[0];
  assign h_node_info_bram_ena = wr_en[1];
  assign h_node_info_bram_wea = wr_en[1];
  assign wgt_bram_ena         = wr_en[2];
  assign wgt_bram_wea         = wr_en[2];
  assign subgraph_bram_ena    = wr_en[3];
  assign subgraph_bram_wea    = wr_en[3];

  assign h_data_bram_load_done      = done[0];
  assign h_node_info_bram_load_done = done[1];
  assign wgt_bram_load_done         = done[2];
  assign subgraph_bram_load_done    = done[3];

endmodule

// File: tb/tb_gat_bram_loader.sv
// Scoreboard bench for gat_bram_loader: stimulus pushes expected BRAM writes, a monitor pops them.
module tb_gat_bram_loader;

  localparam int LEN_W = 18;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_sel;
  logic [LEN_W-1:0] cmd_len;
  logic        s_valid, s_ready;
  logic [31:0] s_data;
  logic        load_clr, busy, cmd_err;
  logic [31:0] h_din, n_din, w_din, g_din;
  logic        h_ena, h_wea, n_ena, n_wea, w_ena, w_wea, g_ena, g_wea;
  logic [19:0] h_addr;
  logic [15:0] n_addr;
  logic [16:0] w_addr;
  logic [15:0] g_addr;
  logic        h_done, n_done, w_done, g_done;
`ifdef GAT_LOADER_CHECKSUM_EN
  logic [31:0] load_checksum;
`endif

  gat_bram_loader #(.TOP_WIDTH(32), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel), .cmd_len(cmd_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .load_clr(load_clr), .busy(busy), .cmd_err(cmd_err),
    .h_data_bram_din(h_din), .h_data_bram_ena(h_ena), .h_data_bram_wea(h_wea), .h_data_bram_addra(h_addr),
    .h_node_info_bram_din(n_din), .h_node_info_bram_ena(n_ena), .h_node_info_bram_wea(n_wea),
    .h_node_info_bram_addra(n_addr),
    .wgt_bram_din(w_din), .wgt_bram_ena(w_ena), .wgt_bram_wea(w_wea), .wgt_bram_addra(w_addr),
    .subgraph_bram_din(g_din), .subgraph_bram_ena(g_ena), .subgraph_bram_wea(g_wea),
    .subgraph_bram_addra(g_addr),
    .h_data_bram_load_done(h_done), .h_node_info_bram_load_done(n_done),
    .wgt_bram_load_done(w_done), .subgraph_bram_load_done(g_done)
`ifdef GAT_LOADER_CHECKSUM_EN
    , .load_checksum(load_checksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  port;
    logic [31:0] addr;
    logic [31:0] data;
    logic        last;
  } wr_t;

  wr_t sb[$];
  int  vectors = 0;
  int  miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      logic [3:0] en;
      logic [3:0] we;
      logic [3:0] dn;
      en = {g_ena, w_ena, n_ena, h_ena};
      we = {g_wea, w_wea, n_wea, h_wea};
      dn = {g_done, w_done, n_done, h_done};
      if (en != we) chk("ena_eq_wea", 32'(we), 32'(en));
      if (en != 4'b0000) begin
        if (sb.size() == 0) begin
          chk("unexpected_write", 32'(en), 32'h0);
        end else begin
          wr_t e;
          logic [31:0] a, d;
          int p;
          e = sb.pop_front();
          p = 0;
          for (int i = 0; i < 4; i++) if (en[i]) p = i;
          case (p)
            0: begin a = 32'(h_addr); d = h_din; end
            1: begin a = 32'(n_addr); d = n_din; end
            2: begin a = 32'(w_addr); d = w_din; end
            default: begin a = 32'(g_addr); d = g_din; end
          endcase
          chk("wr_strobes", 32'(en), 32'(4'b0001 << e.port));
          chk("wr_addr", a, e.addr);
          chk("wr_data", d, e.data);
          chk("wr_done_flag", 32'(dn[e.port]), 32'(e.last));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] sel, input logic [LEN_W-1:0] len);
    int n;
    n = 0;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    if (!cmd_ready) chk("cmd_ready_timeout", 32'(cmd_ready), 32'h1);
    cmd_valid = 1'b1; cmd_sel = sel; cmd_len = len;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic send_word(input logic [1:0] port, input int idx, input logic [31:0] d, input logic last);
    int n;
    wr_t e;
    s_valid = 1'b1; s_data = d;
    n = 0;
    while (!s_ready && n < 50) begin tick(); n++; end
    if (!s_ready) chk("s_ready_timeout", 32'(s_ready), 32'h1);
    e.port = port; e.addr = 32'(idx * 4); e.data = d; e.last = last;
    sb.push_back(e);
    tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin tick(); n++; end
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_sel = '0; cmd_len = '0;
    s_valid = 1'b0; s_data = '0; load_clr = 1'b0;
    repeat (3) tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_strobes", 32'({g_ena, w_ena, n_ena, h_ena}), 32'h0);
    chk("rst_flags", 32'({g_done, w_done, n_done, h_done}), 32'h0);
    rst = 1'b0;
    tick();
    chk("idle_cmd_ready", 32'(cmd_ready), 32'h1);

    // wgt, 4 words back-to-back
    send_cmd(2'd2, 18'd4);
    chk("load_busy", 32'(busy), 32'h1);
    send_word(2, 0, 32'h11, 0);
    send_word(2, 1, 32'h22, 0);
    send_word(2, 2, 32'h33, 0);
    send_word(2, 3, 32'h44, 1);
    s_valid = 1'b0;
    chk("done_s_ready", 32'(s_ready), 32'h0);
    chk("wgt_done_last", 32'(w_done), 32'h1);
    drain();

    // h_data, 3 words with gaps
    send_cmd(2'd0, 18'd3);
    send_word(0, 0, 32'hA0A0_0001, 0);
    s_valid = 1'b0; tick();
    send_word(0, 1, 32'hA0A0_0002, 0);
    s_valid = 1'b0; tick();
    send_word(0, 2, 32'hA0A0_0003, 1);
    s_valid = 1'b0;
    drain();
    chk("h_done", 32'(h_done), 32'h1);
    chk("wgt_done_kept", 32'(w_done), 32'h1);

    // rejected commands: too long and zero length
    send_cmd(2'd1, 18'd13265);
    chk("err_len_big", 32'(cmd_err), 32'h1);
    chk("err_stays_idle", 32'({cmd_ready, busy}), 32'h2);
    tick();
    chk("err_one_cycle", 32'(cmd_err), 32'h0);
    send_cmd(2'd1, 18'd0);
    chk("err_len_zero", 32'(cmd_err), 32'h1);
    tick();
    chk("err_zero_idle", 32'({cmd_ready, busy, cmd_err}), 32'h4);

    // subgraph, load_clr, reload
    send_cmd(2'd3, 18'd2);
    send_word(3, 0, 32'hDEAD_BEEF, 0);
    send_word(3, 1, 32'h1234_5678, 1);
    s_valid = 1'b0;
    drain();
    chk("sub_done", 32'(g_done), 32'h1);
    load_clr = 1'b1; tick(); load_clr = 1'b0;
    chk("clr_flags", 32'({g_done, w_done, n_done, h_done}), 32'h0);
    send_cmd(2'd3, 18'd2);
    send_word(3, 0, 32'h0000_0005, 0);
    send_word(3, 1, 32'h0000_0006, 1);
    s_valid = 1'b0;
    drain();
    chk("sub_reload_done", 32'(g_done), 32'h1);

    // reset mid-load after 2 of 5 words
    send_cmd(2'd2, 18'd5);
    send_word(2, 0, 32'h0BAD_0001, 0);
    send_word(2, 1, 32'h0BAD_0002, 0);
    s_valid = 1'b0;
    rst = 1'b1;
    #1;
    sb.delete();
    chk("midrst_strobes", 32'({g_ena, w_ena, n_ena, h_ena}), 32'h0);
    chk("midrst_flags", 32'({g_done, w_done, n_done, h_done}), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    send_cmd(2'd2, 18'd1);
    send_word(2, 0, 32'h0000_00AB, 1);
    s_valid = 1'b0;
    drain();
    chk("after_rst_done", 32'(w_done), 32'h1);

`ifdef GAT_LOADER_CHECKSUM_EN
    send_cmd(2'd1, 18'd2);
    send_word(1, 0, 32'hFFFF_FFFF, 0);
    send_word(1, 1, 32'h0000_0002, 1);
    s_valid = 1'b0;
    chk("checksum", load_checksum, 32'h0000_0001);
    drain();
`endif

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
